// File: rtl/rx_frame_scheduler_pkg.sv
// Shared types and constants for the RX frame scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_frame_scheduler_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam logic [2:0] GEN3 = 3'd3;
  localparam logic [2:0] GEN4 = 3'd4;
  localparam logic [2:0] GEN5 = 3'd5;

  localparam int BLK_BYTES = 64;
  localparam int IDX_W     = 6;
  localparam int LEN_W     = 5;
  localparam int LEN_SLOTS = 16;

  localparam logic [LEN_W-1:0] DLLP_LEN_DW = 5'd2;

  // Only the 128b/130b generations carry STP/SDP framing tokens.
  function automatic logic gen_framed(input logic [2:0] g);
    return (g == GEN3) || (g == GEN4) || (g == GEN5);
  endfunction

endpackage

// File: rtl/rx_frame_scheduler_lsb_prio_enc.sv
// Lowest-set-bit priority encoder over one 64-byte block mask.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (byte mask), idx (index of lowest set bit, 0 when empty), any (mask non-zero).
module lsb_prio_enc
  import rx_frame_scheduler_pkg::*;
(
  input  logic [BLK_BYTES-1:0] vec,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  // Scan high to low so the last assignment wins with the lowest index.
  always_comb begin
    idx = '0;
    for (int i = BLK_BYTES - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/rx_frame_scheduler.sv
// Captures one 64-byte framed block and issues one descriptor per STP/SDP start.
// Latency: first descriptor valid the cycle after capture; one descriptor per cycle when pkt_ready is high.
// Backpressure: in_ready low while a block is issuing (offered blocks dropped, in_drop pulsed); descriptors held while pkt_ready low.
// Ports: pclk/reset; gen; in_valid/in_ready with data_in, stp_in, sdp_in, end_in, length_in;
//        data_out; pkt_valid/pkt_ready with pkt_type, pkt_start, pkt_len, pkt_last; err_len, in_drop pulses.
module rx_frame_scheduler
  import rx_frame_scheduler_pkg::*;
(
  input  logic                         pclk,
  input  logic                         reset,
  input  logic [2:0]                   gen,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*BLK_BYTES-1:0]       data_in,
  input  logic [BLK_BYTES-1:0]         stp_in,
  input  logic [BLK_BYTES-1:0]         sdp_in,
  input  logic [BLK_BYTES-1:0]         end_in,
  input  logic [LEN_SLOTS*LEN_W-1:0]   length_in,
  output logic [8*BLK_BYTES-1:0]       data_out,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic                         pkt_type,
  output logic [IDX_W-1:0]             pkt_start,
  output logic [LEN_W-1:0]             pkt_len,
  output logic                         pkt_last,
  output logic                         err_len,
  output logic                         in_drop
);

  state_e                       state;
  logic [8*BLK_BYTES-1:0]       data_q;
  logic [BLK_BYTES-1:0]         start_mask;
  logic [BLK_BYTES-1:0]         stp_mask;
  logic [LEN_SLOTS*LEN_W-1:0]   len_q;
  logic [3:0]                   tlp_ord;

  logic [IDX_W-1:0]             sel_idx;
  logic                         sel_any;
  logic                         sel_is_tlp;
  logic [BLK_BYTES-1:0]         sel_bit;
  logic [BLK_BYTES-1:0]         rem_mask;
  logic [LEN_W-1:0]             slot_len;
  logic                         issuing;
  logic                         zero_tlp;
  logic                         retire;

  // END flags only delimit packets upstream; lengths come from the slots.
  logic unused_end;
  assign unused_end = ^end_in;

  lsb_prio_enc u_enc (
    .vec (start_mask),
    .idx (sel_idx),
    .any (sel_any)
  );

  assign issuing    = (state == ST_ISSUE);
  // A byte flagged both STP and SDP is treated as STP.
  assign sel_is_tlp = stp_mask[sel_idx];
  assign sel_bit    = BLK_BYTES'(1) << sel_idx;
  assign rem_mask   = start_mask & ~sel_bit;

  // Slot index is the running count of STPs already retired in this block.
  always_comb begin
    slot_len = '0;
    for (int k = 0; k < LEN_SLOTS; k++) begin
      if (tlp_ord == 4'(k)) slot_len = len_q[k*LEN_W +: LEN_W];
    end
  end

  // Zero-length TLPs are retired without a handshake and flagged.
  assign zero_tlp  = issuing && sel_any && sel_is_tlp && (slot_len == '0);
  assign pkt_valid = issuing && sel_any && !zero_tlp;
  assign retire    = (pkt_valid && pkt_ready) || zero_tlp;

  assign pkt_type  = pkt_valid && !sel_is_tlp;
  assign pkt_start = pkt_valid ? sel_idx : '0;
  assign pkt_len   = !pkt_valid ? '0 : (sel_is_tlp ? slot_len : DLLP_LEN_DW);
  assign pkt_last  = pkt_valid && (rem_mask == '0);

  assign in_ready  = (state == ST_IDLE);
  assign in_drop   = in_valid && issuing;
  assign err_len   = zero_tlp;
  assign data_out  = data_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      data_q     <= '0;
      start_mask <= '0;
      stp_mask   <= '0;
      len_q      <= '0;
      tlp_ord    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && gen_framed(gen)) begin
            data_q     <= data_in;
            start_mask <= stp_in | sdp_in;
            stp_mask   <= stp_in;
            len_q      <= length_in;
            tlp_ord    <= '0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!sel_any) begin
            state <= ST_IDLE;
          end else if (retire) begin
            start_mask <= rem_mask;
            if (sel_is_tlp) tlp_ord <= tlp_ord + 4'd1;
            if (rem_mask == '0) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_scheduler.sv
module tb_rx_frame_scheduler;

  typedef logic [12:0] desc_t; // {type, start[5:0], len[4:0], last}

  typedef struct {
    logic [2:0]      gen;
    logic [63:0]     stp;
    logic [63:0]     sdp;
    logic [79:0]     len;
    int              n;
    logic [2:0][12:0] exp;
    int              errs;
  } vec_t;

  logic         pclk = 1'b0;
  logic         reset;
  logic [2:0]   gen;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] data_in;
  logic [63:0]  stp_in, sdp_in, end_in;
  logic [79:0]  length_in;
  logic [511:0] data_out;
  logic         pkt_valid, pkt_ready, pkt_type, pkt_last, err_len, in_drop;
  logic [5:0]   pkt_start;
  logic [4:0]   pkt_len;

  always #5 pclk = ~pclk;

  rx_frame_scheduler dut (
    .pclk(pclk), .reset(reset), .gen(gen), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .stp_in(stp_in), .sdp_in(sdp_in), .end_in(end_in),
    .length_in(length_in), .data_out(data_out), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_type(pkt_type), .pkt_start(pkt_start),
    .pkt_len(pkt_len), .pkt_last(pkt_last), .err_len(err_len), .in_drop(in_drop)
  );

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  desc_t        exp_q[$];
  logic [511:0] dat_q[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic desc_t mk(input logic t, input int s, input int l, input logic last);
    return {t, 6'(s), 5'(l), last};
  endfunction

  function automatic logic [79:0] slots(input int s0, input int s1, input int s2);
    return {65'd0, 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  function automatic vec_t v(input logic [2:0] g, input logic [63:0] s, input logic [63:0] p,
                             input logic [79:0] l, input int n, input desc_t e0, input desc_t e1,
                             input desc_t e2, input int errs);
    vec_t r;
    r.gen = g; r.stp = s; r.sdp = p; r.len = l; r.n = n;
    r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2; r.errs = errs;
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic desc_t cur_desc();
    return {pkt_type, pkt_start, pkt_len, pkt_last};
  endfunction

  // Scoreboard: pop and compare on every descriptor handshake.
  initial begin
    forever begin
      @(negedge pclk);
      #4;
      if (!reset) begin
        if (pkt_valid && pkt_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_desc: got %0h expected none", cur_desc());
          end else begin
            chk("sb_desc", 512'(cur_desc()), 512'(exp_q.pop_front()));
            chk("sb_data_out", data_out, dat_q.pop_front());
          end
        end
        if (err_len) err_seen++;
      end
    end
  end

  // Presents one block for a single cycle; returns at the negedge of cycle N+1.
  task automatic send(input logic [2:0] g, input logic [63:0] s, input logic [63:0] p,
                      input logic [79:0] l, input logic [511:0] d);
    @(negedge pclk);
    gen = g; stp_in = s; sdp_in = p; end_in = s; length_in = l; data_in = d; in_valid = 1'b1;
    @(negedge pclk);
    in_valid = 1'b0; stp_in = '0; sdp_in = '0; data_in = ~d;
  endtask

  vec_t         vecs[11];
  logic [511:0] d;
  int           base, cyc;

  initial begin
    reset = 1'b1; gen = 3'd0; in_valid = 1'b0; data_in = '0; stp_in = '0; sdp_in = '0;
    end_in = '0; length_in = '0; pkt_ready = 1'b0;

    vecs[0]  = v(3'd3, 64'h1, 64'h0, slots(4, 0, 0), 1, mk(0, 0, 4, 1), 0, 0, 0);
    vecs[1]  = v(3'd4, 64'h100, 64'h1, slots(3, 0, 0), 2, mk(1, 0, 2, 0), mk(0, 8, 3, 1), 0, 0);
    vecs[2]  = v(3'd2, 64'h1, 64'h0, slots(4, 0, 0), 0, 0, 0, 0, 0);
    vecs[3]  = v(3'd3, 64'h10, 64'h0, slots(0, 0, 0), 0, 0, 0, 0, 1);
    vecs[4]  = v(3'd5, 64'h0000_0100_0010_0004, 64'h4000_0000, slots(1, 0, 7), 3,
                 mk(0, 2, 1, 0), mk(1, 30, 2, 0), mk(0, 40, 7, 1), 1);
    vecs[5]  = v(3'd3, 64'h400, 64'h400, slots(9, 0, 0), 1, mk(0, 10, 9, 1), 0, 0, 0);
    vecs[6]  = v(3'd4, 64'h0, 64'h0, slots(0, 0, 0), 0, 0, 0, 0, 0);
    vecs[7]  = v(3'd5, 64'h0, 64'h8000_0000_0000_0020, slots(0, 0, 0), 2,
                 mk(1, 5, 2, 0), mk(1, 63, 2, 1), 0, 0);
    vecs[8]  = v(3'd3, 64'h8000_0000_0000_0000, 64'h0, slots(31, 0, 0), 1, mk(0, 63, 31, 1), 0, 0, 0);
    vecs[9]  = v(3'd3, 64'h202, 64'h0, slots(5, 0, 0), 1, mk(0, 1, 5, 0), 0, 0, 1);
    vecs[10] = v(3'd7, 64'h1, 64'h1, slots(4, 0, 0), 0, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge pclk);
    #4;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_desc", 512'(cur_desc()), 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_pulses", {err_len, in_drop}, 0);
    @(negedge pclk);
    reset = 1'b0;

    // Single TLP, first descriptor in N+1, in_ready back in N+2.
    pkt_ready = 1'b1;
    d = rnd512();
    exp_q.push_back(mk(0, 0, 4, 1)); dat_q.push_back(d);
    send(3'd3, 64'h1, 64'h0, slots(4, 0, 0), d);
    #4;
    chk("a_valid_n1", pkt_valid, 1);
    chk("a_desc_n1", 512'(cur_desc()), 512'(mk(0, 0, 4, 1)));
    chk("a_in_ready_n1", in_ready, 0);
    @(negedge pclk); #4;
    chk("a_in_ready_n2", in_ready, 1);
    chk("a_valid_n2", pkt_valid, 0);

    // DLLP then TLP on back-to-back cycles.
    d = rnd512();
    exp_q.push_back(mk(1, 0, 2, 0)); dat_q.push_back(d);
    exp_q.push_back(mk(0, 8, 3, 1)); dat_q.push_back(d);
    send(3'd4, 64'h100, 64'h1, slots(3, 0, 0), d);
    #4;
    chk("b_desc0", 512'({pkt_valid, cur_desc()}), 512'({1'b1, mk(1, 0, 2, 0)}));
    @(negedge pclk); #4;
    chk("b_desc1", 512'({pkt_valid, cur_desc()}), 512'({1'b1, mk(0, 8, 3, 1)}));
    @(negedge pclk); #4;
    chk("b_in_ready", in_ready, 1);

    // Stall three cycles, offered block meanwhile is dropped.
    pkt_ready = 1'b0;
    d = rnd512();
    exp_q.push_back(mk(0, 0, 6, 0)); dat_q.push_back(d);
    exp_q.push_back(mk(0, 16, 2, 1)); dat_q.push_back(d);
    send(3'd3, 64'h1_0001, 64'h0, slots(6, 2, 0), d);
    #4;
    chk("c_hold1", 512'({pkt_valid, cur_desc()}), 512'({1'b1, mk(0, 0, 6, 0)}));
    chk("c_drop_idle", in_drop, 0);
    @(negedge pclk);
    in_valid = 1'b1; stp_in = 64'h8; length_in = slots(9, 9, 9); data_in = rnd512();
    #4;
    chk("c_hold2", 512'({pkt_valid, cur_desc()}), 512'({1'b1, mk(0, 0, 6, 0)}));
    chk("c_in_drop", in_drop, 1);
    @(negedge pclk);
    in_valid = 1'b0; stp_in = '0;
    #4;
    chk("c_hold3", 512'({pkt_valid, cur_desc()}), 512'({1'b1, mk(0, 0, 6, 0)}));
    chk("c_in_drop_end", in_drop, 0);
    @(negedge pclk);
    pkt_ready = 1'b1;
    #4;
    chk("c_hold4", 512'({pkt_valid, cur_desc()}), 512'({1'b1, mk(0, 0, 6, 0)}));
    chk("c_data_held", data_out, d);
    @(negedge pclk); #4;
    chk("c_second", 512'({pkt_valid, cur_desc()}), 512'({1'b1, mk(0, 16, 2, 1)}));
    @(negedge pclk); #4;
    chk("c_in_ready", in_ready, 1);

    // Unframed generation: ignored entirely.
    send(3'd2, 64'hff, 64'h0, slots(4, 4, 4), rnd512());
    #4;
    chk("d_gen2_ready", in_ready, 1);
    chk("d_gen2_valid", pkt_valid, 0);

    // Zero-length TLP: err_len in N+1, no descriptor, idle in N+2.
    send(3'd3, 64'h10, 64'h0, slots(0, 0, 0), rnd512());
    #4;
    chk("d_err_pulse", {err_len, pkt_valid}, 2'b10);
    @(negedge pclk); #4;
    chk("d_err_end", {err_len, pkt_valid, in_ready}, 3'b001);

    // Reset while a descriptor is pending.
    pkt_ready = 1'b0;
    send(3'd3, 64'h1, 64'h0, slots(5, 0, 0), rnd512());
    #4;
    chk("e_valid_pre", pkt_valid, 1);
    @(negedge pclk);
    reset = 1'b1;
    #1;
    chk("e_valid_rst", pkt_valid, 0);
    chk("e_ready_rst", in_ready, 1);
    @(negedge pclk);
    reset = 1'b0;
    pkt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("e_no_desc", pkt_valid, 0);
      @(negedge pclk);
    end

    // Table-driven blocks with random descriptor backpressure.
    for (int t = 0; t < 11; t++) begin
      base = err_seen;
      d = rnd512();
      for (int j = 0; j < vecs[t].n; j++) begin
        exp_q.push_back(vecs[t].exp[j]);
        dat_q.push_back(d);
      end
      send(vecs[t].gen, vecs[t].stp, vecs[t].sdp, vecs[t].len, d);
      cyc = 0;
      forever begin
        pkt_ready = ($urandom_range(0, 3) != 0);
        #4;
        if (exp_q.size() == 0 && in_ready && !pkt_valid) break;
        cyc++;
        if (cyc > 200) begin
          checks++;
          errors++;
          $display("FAIL vec%0d_timeout: got %0d pending expected 0", t, exp_q.size());
          exp_q.delete();
          dat_q.delete();
          break;
        end
        @(negedge pclk);
      end
      chk($sformatf("vec%0d_err_len", t), 512'(err_seen - base), 512'(vecs[t].errs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_scheduler.md
RX_FRAME_SCHEDULER -- requirements
Module: rx_frame_scheduler

Interface
REQ-001 SHALL: pclk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL: gen  in  3  link generation; 3/4/5 = 128b/130b framing active.
REQ-004 SHALL: in_valid  in  1  64-byte block present (length-counter wr_out).
REQ-005 SHALL: in_ready  out  1  scheduler can capture a block this cycle.
REQ-006 SHALL: data_in  in  512  block bytes; byte i = data_in[8i+7:8i].
REQ-007 SHALL: stp_in / sdp_in / end_in  in  64 each  per-byte STP, SDP, END flags.
REQ-008 SHALL: length_in  in  80  16 x 5-bit TLP DW lengths; slot k = length_in[5k+4:5k], k = ordinal of the STP in the block.
REQ-009 SHALL: data_out  out  512  captured block, stable while any of its packets is issued.
REQ-010 SHALL: pkt_valid  out  1 / pkt_ready  in  1  packet descriptor handshake.
REQ-011 SHALL: pkt_type  out  1 (0 TLP, 1 DLLP); pkt_start  out  6 (start byte index); pkt_len  out  5 (DWs); pkt_last  out  1 (final packet of block).
REQ-012 SHALL: err_len  out  1  one-cycle pulse, TLP with length slot 0 dropped.
REQ-013 SHALL: in_drop  out  1  one-cycle pulse, in_valid while in_ready low.

Function
REQ-014 SHALL: two states, IDLE and ISSUE; in_ready = 1 exactly in IDLE.
REQ-015 SHALL: IDLE with in_valid and gen in {3,4,5}: register data, masks, length_in; start mask = stp_in | sdp_in; go to ISSUE.
REQ-016 SHALL: IDLE with in_valid and other gen: block discarded, stay IDLE, no packet, no pulse.
REQ-017 SHALL: a block whose start mask is zero returns to IDLE the cycle after capture, no pkt_valid.
REQ-018 SHALL: packet selection = lowest set bit of remaining start mask; if STP and SDP set on one byte, STP wins.
REQ-019 SHALL: TLP pkt_len = length slot of its STP ordinal; DLLP pkt_len = 2.
REQ-020 SHALL: first descriptor registered, pkt_valid high in cycle N+1 after capture edge N.
REQ-021 SHALL: descriptor fields held constant while pkt_valid high and pkt_ready low.
REQ-022 SHALL: on handshake, clear issued bit; next descriptor valid next cycle (no bubble); pkt_ready ignored while pkt_valid low.
REQ-023 SHALL: pkt_last = 1 when no other start bit remains; its handshake returns to IDLE, in_ready = 1 next cycle.
REQ-024 SHALL: TLP with slot 0 skipped, err_len pulsed in the cycle it is evaluated, TLP ordinal still advanced.
REQ-025 SHALL: in_valid during ISSUE ignored, in_drop pulsed, state unaffected.
REQ-026 SHALL: gen changes during ISSUE ignored until the block completes.

Reset
REQ-027 SHALL: reset asserted: state IDLE, in_ready 1, pkt_valid 0, pkt_type/pkt_start/pkt_len/pkt_last 0, data_out 0, err_len 0, in_drop 0, masks 0.
REQ-028 SHALL: reset mid-ISSUE discards the captured block with no further descriptors.

Structure
REQ-029 SHALL: shared package holds state enum, GEN3/GEN4/GEN5 codes, DLLP_LEN_DW = 2, block byte count 64, length slot width 5.
REQ-030 SHALL: one sub-module, lsb_prio_enc (64-bit lowest-set-bit index + any-set flag).

Verification
REQ-031 SHALL: gen=3, STP byte 0 with slot0=4, END byte 15, pkt_ready=1 -> one descriptor TLP start 0 len 4 last 1 at N+1; in_ready 1 at N+2.
REQ-032 SHALL: gen=4, SDP byte 0, STP byte 8 slot0=3 -> DLLP start 0 len 2, then TLP start 8 len 3 last 1 on consecutive cycles.
REQ-033 SHALL: two TLPs, pkt_ready low 3 cycles -> first descriptor stable 4 cycles; in_valid pulse meanwhile -> in_drop 1 for one cycle.
REQ-034 SHALL: gen=2 block with STP bits -> no pkt_valid, in_ready remains 1; STP byte 4 with slot0=0 -> err_len pulse, no descriptor.
REQ-035 SHALL: reset asserted while pkt_valid high -> pkt_valid 0 immediately, in_ready 1, no later descriptor from that block.
